// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter.
//   arb_state_e  : sequencer states
//   M0 / M1      : master index constants (bit positions in grant/ready)
//   RD_LAT_MIN/MAX : legal range of the RAM read latency
//   cnt_width()  : width of the WAIT down-counter for a given latency
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int M0 = 0;
    localparam int M1 = 1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two masters and the RAM.
//   slave  : arbiter view (takes requests and RAM read data, drives
//            responses, RAM controls, grant and busy)
//   master : environment view (masters plus RAM)
interface mem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              m0_req,   m1_req;
    logic              m0_we,    m1_we;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_ready, m1_ready;

    logic              ram_we;
    logic [ADDR_W-3:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, ram_dout,
        output m0_rdata, m1_rdata, m0_ready, m1_ready,
               ram_we, ram_addr, ram_din, grant, busy
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, ram_dout,
        input  m0_rdata, m1_rdata, m0_ready, m1_ready,
               ram_we, ram_addr, ram_din, grant, busy
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way winner pick.
//   req        : request vector, bit i = master i
//   last_grant : index of the master served last
//   rr_en      : 1 = alternate on ties, 0 = master 0 always wins ties
//   win        : one-hot winner, 00 when nobody requests
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            if (rr_en && (last_grant == 1'(M0))) begin
                win = 2'b10;
            end else begin
                win = 2'b01;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter / sequencer for a single-port word RAM.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave -- master requests/responses, RAM
//           address/we/din/dout, one-hot grant and busy
//
// state | meaning
// IDLE  | no owner; sample requests and latch the winner's command
// ISSUE | one cycle with address/data on the RAM, ram_we = latched we
// WAIT  | RD_LAT cycles for read data; capture ram_dout at the end
// RESP  | one-cycle ready pulse to the owner; remember it as last owner
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus
);

    // Out-of-range latencies saturate to the nearest legal value.
    localparam int LAT     = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                             (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam int CNT_W   = cnt_width(LAT);
    localparam int WADDR_W = ADDR_W - 2;

    arb_state_e          state_q,      state_d;
    logic [1:0]          grant_q,      grant_d;
    logic                last_grant_q, last_grant_d;
    logic                ram_we_q,     ram_we_d;
    logic [WADDR_W-1:0]  ram_addr_q,   ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q,    ram_din_d;
    logic [DATA_W-1:0]   rdata_q,      rdata_d;
    logic [1:0]          ready_q,      ready_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [1:0]          win;

    // Byte-lane bits of the master addresses are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.m0_addr[1:0], bus.m1_addr[1:0]};

    rr_pick2 u_pick (
        .req        ({bus.m1_req, bus.m0_req}),
        .last_grant (last_grant_q),
        .rr_en      (RR_EN != 0),
        .win        (win)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        rdata_d      = rdata_q;
        ready_d      = 2'b00;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (win != 2'b00) begin
                    grant_d = win;
                    state_d = ISSUE;
                    if (win[M1]) begin
                        ram_we_d   = bus.m1_we;
                        ram_addr_d = bus.m1_addr[ADDR_W-1:2];
                        ram_din_d  = bus.m1_wdata;
                    end else begin
                        ram_we_d   = bus.m0_we;
                        ram_addr_d = bus.m0_addr[ADDR_W-1:2];
                        ram_din_d  = bus.m0_wdata;
                    end
                end
            end
            ISSUE: begin
                // ram_we_q still holds the latched command type here.
                if (ram_we_q) begin
                    state_d = RESP;
                    ready_d = grant_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rdata_d = bus.ram_dout;
                    ready_d = grant_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d      = IDLE;
                grant_d      = 2'b00;
                last_grant_d = grant_q[M1];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'(M1);
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            rdata_q      <= '0;
            ready_q      <= 2'b00;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.m0_rdata = rdata_q;
    assign bus.m1_rdata = rdata_q;
    assign bus.m0_ready = ready_q[M0];
    assign bus.m1_ready = ready_q[M1];
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter and sequencer for the single-port word RAM behind the multi-cycle CPU. It shares the RAM between master 0 (the CPU bus) and master 1 (a loader/DMA port) and issues one access at a time. It drives RAM address, write-enable and write data, captures read data after the RAM's fixed latency, and returns a one-cycle ready pulse that feeds the CPU's `mio_ready`.

## Interface
Parameters:
- `ADDR_W`, 13: byte address width from masters; RAM word address is `ADDR_W-2` bits.
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: cycles from RAM address presented to `ram_dout` valid; legal range 1..4.
- `RR_EN`, 1: 1 selects round-robin arbitration; 0 gives master 0 fixed priority.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `m0_req`, `m1_req` in 1: access request, held until ready.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in ADDR_W: byte address; bits [1:0] are ignored.
- `m0_wdata`, `m1_wdata` in DATA_W: write data.
- `m0_rdata`, `m1_rdata` out DATA_W: read data, valid while ready=1.
- `m0_ready`, `m1_ready` out 1: one-cycle completion pulse.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W-2: RAM word address, equal to `addr[ADDR_W-1:2]`.
- `ram_din` out DATA_W: RAM write data.
- `ram_dout` in DATA_W: RAM read data.
- `grant` out 2: one-hot current owner; 00 when idle.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any req is high, pick the winner and latch its we, addr and wdata. Set `grant` and go to ISSUE. With no req, stay in IDLE.
- **Arbitration, RR_EN=1:** a lone requester wins. On a tie, the master not granted last wins.
  - `last_grant` resets to master 1, so master 0 wins the first tie.
- **Arbitration, RR_EN=0:** master 0 wins every tie.
- **ISSUE (one cycle):** drive `ram_addr` and `ram_din` from the latched values. `ram_we` equals the latched we in this cycle only. A write goes to RESP; a read goes to WAIT.
- **WAIT (exactly RD_LAT cycles):** hold `ram_addr`; `ram_we` stays 0. A down-counter sized for RD_LAT sets the length. On the edge that ends the last WAIT cycle, capture `ram_dout` into the read-data register.
- **RESP (one cycle):** assert the granted master's ready. Drive the captured data on both rdata outputs; only the granted master's ready is high. Update `last_grant`, then go to IDLE.
- A master whose req is still high in the IDLE cycle after its ready is a new transaction. Masters must drop req in the ready cycle to avoid a repeat access.
- Requests that arrive or drop mid-transaction are not observed until IDLE. Dropping req early does not abort the access.

## Timing
- Label the rising edge where IDLE samples req as edge 0.
- ISSUE occupies cycle 1.
- Write: ready=1 in cycle 2. The RAM write is performed in cycle 1.
- Read: ready=1 in cycle 2+RD_LAT, which is cycle 3 when RD_LAT=1.
- Back-to-back: the next IDLE follows RESP, so minimum spacing is 3 cycles per write and 3+RD_LAT cycles per read.
- Reset (low) forces, asynchronously:
  - FSM to IDLE and `last_grant` to 1;
  - `grant`=00, `busy`=0, both ready=0, `ram_we`=0;
  - `ram_addr`=0, `ram_din`=0, both rdata=0.
- Reset during a transaction aborts it: no ready is issued, and `ram_we` drops immediately.
- Outputs are registered or decoded from the state only; no combinational path from req to RAM signals.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - master index constants M0=0, M1=1;
  - RD_LAT legal-range constants.
- Sub-module `rr_pick2`: combinational two-input pick.
  - Inputs: req[1:0], last_grant, rr_en.
  - Output: one-hot winner.

## Test plan
- **Single write, then read:** m0 write addr 0x0010, data 0xDEADBEEF. Expect `ram_we`=1 with `ram_addr`=0x004 in cycle 1 and m0_ready in cycle 2. Then an m0 read of 0x0010 returns 0xDEADBEEF with ready in cycle 3 (RD_LAT=1).
- **Tie, RR_EN=1:** both masters hold read requests. Grants go m0, m1, m0, m1 over four transactions, each completing 4 cycles apart.
- **Tie, RR_EN=0:** both masters request continuously. Every grant goes to m0; m1 is served only after m0_req drops.
- **RD_LAT=3:** a read request at edge 0 gives ready in cycle 5. rdata equals the RAM model value, and `ram_addr` is stable for cycles 1-4.
- **Reset mid-read:** reset goes low during WAIT. All outputs go to 0 immediately, and no ready pulse appears after reset releases. The first tie after reset goes to m0.
- **Held req:** m1 keeps req high after ready. A second identical access starts in the following IDLE cycle.
